pic_bus_buffer: RTL and testbench

Clocked, parametrised successor to the PIC data bus buffer. Synchronises the asynchronous CPU strobes (cs_n, rd_n, wr_n, a0) to clk and queues completed CPU writes in a small FIFO for the control/ICW-OCW logic. Serves CPU reads through a request/acknowledge handshake with control logic, and owns the tristate enable of the shared data bus. Sits between the CPU pins and the read/write and control logic.

---
 rtl/pic_bus_pkg.sv | 22 ++
 rtl/pic_sync_fifo.sv | 52 +++++
 rtl/pic_bus_buffer.sv | 179 +++++++++++++++++
 tb/tb_pic_bus_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_bus_pkg.sv
// Shared constants and types for the clocked PIC data bus buffer:
// read FSM state encodings, default widths and the write-queue entry layout.
package pic_bus_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_RD_TIMEOUT  = 15;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t ST_IDLE  = 2'd0;
    localparam rd_state_t ST_WAIT  = 2'd1;
    localparam rd_state_t ST_DRIVE = 2'd2;

    // One queued CPU write at the default bus width: address bit above data.
    typedef struct packed {
        logic                  a0;
        logic [DEF_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/pic_sync_fifo.sv
// Circular synchronous FIFO used as the CPU write queue. A push into a full
// FIFO only lands when a pop happens in the same cycle.
module pic_sync_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pic_bus_buffer.sv
// Clocked PIC data bus buffer: synchronises CPU strobes, queues writes, serves
// reads via rd_req/rd_ack and owns the data bus enable. Optional: RD_TIMEOUT_EN.
module pic_bus_buffer
    import pic_bus_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int RD_TIMEOUT  = DEF_RD_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              a0,
    inout  wire  [DATA_W-1:0] d,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_a0,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              rd_req,
    output logic              rd_a0,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_ack,
    output logic              d_oe,
    output logic              wr_overflow,
    output rd_state_t         dbg_state
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (RD_TIMEOUT < 1) begin : g_bad_timeout
        $error("RD_TIMEOUT must be >= 1");
    end

    logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync, a0_sync;
    logic [DATA_W-1:0]      d_sync [SYNC_STAGES];
    logic                   s_cs_n, s_rd_n, s_wr_n, s_a0;
    logic [DATA_W-1:0]      s_d;
    logic                   p_cs_n, p_rd_n, p_wr_n, p_a0;
    logic [DATA_W-1:0]      p_d;

    assign s_cs_n = cs_sync[SYNC_STAGES-1];
    assign s_rd_n = rd_sync[SYNC_STAGES-1];
    assign s_wr_n = wr_sync[SYNC_STAGES-1];
    assign s_a0   = a0_sync[SYNC_STAGES-1];
    assign s_d    = d_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync <= '1;
            rd_sync <= '1;
            wr_sync <= '1;
            a0_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) d_sync[i] <= '0;
            p_cs_n  <= 1'b1;
            p_rd_n  <= 1'b1;
            p_wr_n  <= 1'b1;
            p_a0    <= 1'b0;
            p_d     <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            rd_sync   <= {rd_sync[SYNC_STAGES-2:0], rd_n};
            wr_sync   <= {wr_sync[SYNC_STAGES-2:0], wr_n};
            a0_sync   <= {a0_sync[SYNC_STAGES-2:0], a0};
            d_sync[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) d_sync[i] <= d_sync[i-1];
            p_cs_n    <= s_cs_n;
            p_rd_n    <= s_rd_n;
            p_wr_n    <= s_wr_n;
            p_a0      <= s_a0;
            p_d       <= s_d;
        end
    end

    // Write queue handshake: the head is offered while wr_valid=1 and is
    // consumed on any clock edge where wr_valid && wr_ready; wr_valid does not
    // depend on wr_ready, and wr_ready while empty has no effect.
    logic              wr_evt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   head;

    // Also requiring p_rd_n keeps a joint rd_n/wr_n release from looking like a write.
    assign wr_evt = !p_wr_n && s_wr_n && !p_cs_n && s_rd_n && p_rd_n;

    pic_sync_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_evt),
        .push_data ({p_a0, p_d}),
        .pop       (wr_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr_valid = !fifo_empty;
    assign wr_a0    = head[DATA_W];
    assign wr_data  = head[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst)                                   wr_overflow <= 1'b0;
        else if (wr_evt && fifo_full && !wr_ready) wr_overflow <= 1'b1;
    end

    rd_state_t         state;
    logic [DATA_W-1:0] hold;
    logic              rd_start;
    logic              rd_release;

    assign rd_start   = !s_rd_n && p_rd_n && !s_cs_n;
    assign rd_release = s_rd_n || s_cs_n;

`ifdef RD_TIMEOUT_EN
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;

    assign timeout_hit = (to_cnt == TW'(RD_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT) to_cnt <= '0;
        else                         to_cnt <= to_cnt + TW'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rd_req <= 1'b0;
            rd_a0  <= 1'b0;
            hold   <= '0;
        end else begin
            rd_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_start) begin
                        rd_req <= 1'b1;
                        rd_a0  <= s_a0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A strobe release abandons the read; a late ack then finds IDLE.
                    if (rd_release) begin
                        state <= ST_IDLE;
                    end else if (rd_ack) begin
                        hold  <= rd_data;
                        state <= ST_DRIVE;
                    end
`ifdef RD_TIMEOUT_EN
                    else if (timeout_hit) begin
                        hold  <= '1;
                        state <= ST_DRIVE;
                    end
`endif
                end
                ST_DRIVE: begin
                    if (rd_release) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign d_oe      = (state == ST_DRIVE);
    assign d         = d_oe ? hold : {DATA_W{1'bz}};
    assign dbg_state = state;

endmodule

// File: tb/tb_pic_bus_buffer.sv
// Self-checking bench for pic_bus_buffer: writes are scoreboarded through an
// expected queue, reads and resets are checked directly against constants.
module tb_pic_bus_buffer;
    import pic_bus_pkg::*;

    localparam int DATA_W = 8;
    localparam int SYNC   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
    logic              wr_ready = 1'b0, rd_ack = 1'b0;
    logic [DATA_W-1:0] rd_data = '0, cpu_d = '0;
    logic              cpu_d_oe = 1'b0;
    wire  [DATA_W-1:0] d;
    logic [DATA_W-1:0] wr_data;
    logic              wr_a0, wr_valid, rd_req, rd_a0, d_oe, wr_overflow;
    rd_state_t         dbg_state;

    logic [DATA_W:0]   exp_q[$];
    logic [DATA_W:0]   exp_v;
    int                n_vec = 0;
    int                n_err = 0;

    assign d = cpu_d_oe ? cpu_d : {DATA_W{1'bz}};

    pic_bus_buffer dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
        .d(d), .wr_data(wr_data), .wr_a0(wr_a0), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_req(rd_req), .rd_a0(rd_a0), .rd_data(rd_data),
        .rd_ack(rd_ack), .d_oe(d_oe), .wr_overflow(wr_overflow), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // scoreboard: pop takes effect at the next rising edge
    always @(negedge clk) begin
        if (!rst && wr_valid && wr_ready) begin
            check("pop_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                check("pop_entry", {23'd0, wr_a0, wr_data}, {23'd0, exp_v});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
        wr_ready = 1'b0; rd_ack = 1'b0;
        tick(2);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic cpu_write(input logic a, input logic [DATA_W-1:0] v,
                             input int low_cycles, input bit keep);
        cs_n = 1'b0; a0 = a; cpu_d = v; cpu_d_oe = 1'b1; wr_n = 1'b0;
        tick(low_cycles);
        wr_n = 1'b1;
        if (keep) exp_q.push_back({a, v});
    endtask

    task automatic drain();
        wr_ready = 1'b1;
        for (int i = 0; i < 20 && wr_valid; i++) tick(1);
        wr_ready = 1'b0;
        check("drain_empty", wr_valid, 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !rd_req; i++) tick(1);
        check("rd_req_seen", rd_req, 1);
    endtask

    task automatic cpu_read(input logic a, input int ack_delay,
                            input logic [DATA_W-1:0] v, output int req_cnt);
        cs_n = 1'b0; a0 = a; cpu_d_oe = 1'b0; rd_n = 1'b0;
        wait_req();
        req_cnt = 32'(rd_req);
        for (int i = 0; i < ack_delay; i++) begin
            tick(1);
            req_cnt += 32'(rd_req);
        end
        rd_ack = 1'b1; rd_data = v;
        tick(1);
        req_cnt += 32'(rd_req);
        rd_ack = 1'b0; rd_data = '0;
    endtask

    initial begin
        int cnt;
        int n;

        tick(3);
        rst = 1'b0;
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_wr_a0", wr_a0, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_rd_a0", rd_a0, 0);
        check("rst_d_oe", d_oe, 0);
        check("rst_overflow", wr_overflow, 0);
        check("rst_state", dbg_state, ST_IDLE);

        // single write, latency SYNC+1 edges after wr_n rises
        cpu_write(1'b1, 8'h13, 3, 1'b1);
        tick(1); check("wr_lat_e1", wr_valid, 0);
        tick(1); check("wr_lat_e2", wr_valid, 0);
        tick(1); check("wr_lat_e3", wr_valid, 1);
        check("wr_head_data", wr_data, 8'h13);
        check("wr_head_a0", wr_a0, 1);
        wr_ready = 1'b1;
        tick(1);
        wr_ready = 1'b0;
        check("wr_pop_empty", wr_valid, 0);

        // overflow: fifth write dropped
        for (int i = 1; i <= 5; i++) begin
            cpu_write(i[0], 8'(i), 2, i <= 4);
            tick(SYNC + 2);
            if (i == 4) check("ovf_before", wr_overflow, 0);
        end
        check("ovf_set", wr_overflow, 1);
        drain();
        check("ovf_sticky", wr_overflow, 1);
        reset_dut();
        check("ovf_cleared", wr_overflow, 0);

        // full FIFO: push and pop land on the same edge
        for (int i = 1; i <= 4; i++) begin
            cpu_write(1'b0, 8'(8'h10 + i), 2, 1'b1);
            tick(SYNC + 2);
        end
        cpu_write(1'b1, 8'h15, 2, 1'b1);
        tick(SYNC);
        wr_ready = 1'b1;
        tick(1);
        check("full_pp_no_ovf", wr_overflow, 0);
        drain();
        check("full_pp_ovf_end", wr_overflow, 0);

        // read with ack two cycles after rd_req
        cpu_read(1'b1, 2, 8'hA5, cnt);
        check("rd_req_pulses", cnt, 1);
        check("rd_d_oe", d_oe, 1);
        check("rd_d", d, 8'hA5);
        check("rd_a0", rd_a0, 1);
        check("rd_state", dbg_state, ST_DRIVE);
        tick(3);
        check("rd_d_hold", d, 8'hA5);
        rd_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10 && d_oe; i++) begin
            tick(1);
            n++;
        end
        check("rd_release_lat", n, SYNC + 1);
        check("rd_d_oe_off", d_oe, 0);

        // abort: strobe released during WAIT, ack arrives later
        tick(2);
        a0 = 1'b0; rd_n = 1'b0;
        wait_req();
        rd_n = 1'b1;
        tick(5);
        rd_ack = 1'b1; rd_data = 8'h5A;
        tick(1);
        rd_ack = 1'b0; rd_data = '0;
        tick(3);
        check("abort_d_oe", d_oe, 0);
        check("abort_state", dbg_state, ST_IDLE);
        check("abort_rd_a0", rd_a0, 0);

`ifdef RD_TIMEOUT_EN
        // no ack: timeout drives all-ones
        rd_n = 1'b0;
        wait_req();
        for (int i = 0; i < 40 && !d_oe; i++) tick(1);
        check("to_d_oe", d_oe, 1);
        check("to_d", d, 8'hFF);
        rd_n = 1'b1;
        tick(SYNC + 3);
`endif

        // reset during DRIVE with a queued write
        cpu_write(1'b1, 8'h77, 2, 1'b1);
        tick(SYNC + 2);
        check("rst_pre_valid", wr_valid, 1);
        cpu_read(1'b0, 1, 8'h3C, cnt);
        check("rst_pre_drive", d_oe, 1);
        rst = 1'b1; rd_n = 1'b1;
        tick(1);
        check("rst_mid_d_oe", d_oe, 0);
        check("rst_mid_valid", wr_valid, 0);
        check("rst_mid_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        exp_q.delete();
        tick(SYNC + 2);

        // rd_n and wr_n low together: read wins, no push
        cs_n = 1'b0; cpu_d_oe = 1'b0; a0 = 1'b1;
        rd_n = 1'b0; wr_n = 1'b0;
        wait_req();
        tick(1);
        rd_ack = 1'b1; rd_data = 8'hC3;
        tick(1);
        rd_ack = 1'b0;
        check("both_d_oe", d_oe, 1);
        check("both_d", d, 8'hC3);
        rd_n = 1'b1; wr_n = 1'b1;
        tick(SYNC + 6);
        check("both_no_push", wr_valid, 0);
        check("both_state", dbg_state, ST_IDLE);
        check("end_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
